// File: rtl/jtlabrun_colmix_if.sv
// CPU-side palette bus of the Labyrinth Runner colour mixer.
// The master drives the decoded access; the slave returns registered read data.
interface jtlabrun_colmix_if;
  logic       cpu_cen;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic       cpu_rnw;
  logic       pal_cs;
  logic [7:0] pal_dout;

  modport master (
    output cpu_cen, cpu_addr, cpu_dout, cpu_rnw, pal_cs,
    input  pal_dout
  );

  modport slave (
    input  cpu_cen, cpu_addr, cpu_dout, cpu_rnw, pal_cs,
    output pal_dout
  );
endinterface

// File: rtl/jtlabrun_colmix.sv
// Labyrinth Runner palette: CPU-writable xBGR555 RAM (even/odd byte banks)
// and a two-stage pixel pipeline with matching blanking delay.
module jtlabrun_colmix #(
  parameter int BLANK_DLY = 2  // must equal the RGB pipeline latency (>= 2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pxl_cen,
  jtlabrun_colmix_if.slave    bus,
  input  logic [6:0]          pxl,
  input  logic                LHBL,
  input  logic                LVBL,
  output logic [4:0]          red,
  output logic [4:0]          green,
  output logic [4:0]          blue,
  output logic                LHBL_dly,
  output logic                LVBL_dly
);

  logic [7:0] r_pal_even [0:127];
  logic [7:0] r_pal_odd  [0:127];

  logic [6:0] w_cpu_idx;
  logic       w_cpu_we;

  logic [6:0] r_hi;
  logic [7:0] r_lo;
  logic [4:0] w_r, w_g, w_b;
  logic       w_show;

  logic [BLANK_DLY-1:0] r_lhbl_sr;
  logic [BLANK_DLY-1:0] r_lvbl_sr;
  logic [4:0]           r_red, r_green, r_blue;
  logic [7:0]           r_pal_dout;

  assign w_cpu_idx = bus.cpu_addr[7:1];
  assign w_cpu_we  = bus.pal_cs && !bus.cpu_rnw && bus.cpu_cen;

  // NOTE: palette RAM has no reset branch so it maps onto block RAM;
  // its contents survive rst by design.
  always_ff @(posedge clk) begin
    if (w_cpu_we) begin
      if (bus.cpu_addr[0]) r_pal_odd[w_cpu_idx]  <= bus.cpu_dout;
      else                 r_pal_even[w_cpu_idx] <= bus.cpu_dout;
    end
  end

  // Read-back ignores pal_cs; a read in the write clk sees the old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pal_dout <= '0;
    end else begin
      r_pal_dout <= bus.cpu_addr[0] ? r_pal_odd[w_cpu_idx] : r_pal_even[w_cpu_idx];
    end
  end

  assign bus.pal_dout = r_pal_dout;

  // Stage 1: fetch both bytes of the entry; the x bit is not needed here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (pxl_cen) begin
      r_hi <= r_pal_even[pxl][6:0];
      r_lo <= r_pal_odd[pxl];
    end
  end

  assign w_b = r_hi[6:2];
  assign w_g = {r_hi[1:0], r_lo[7:5]};
  assign w_r = r_lo[4:0];

  // Blank bit paired with the pixel now in stage 1 is the one about to
  // enter the last delay stage, so RGB and *_dly change together.
  assign w_show = r_lhbl_sr[BLANK_DLY-2] & r_lvbl_sr[BLANK_DLY-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lhbl_sr <= '0;
      r_lvbl_sr <= '0;
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
    end else if (pxl_cen) begin
      r_lhbl_sr <= {r_lhbl_sr[BLANK_DLY-2:0], LHBL};
      r_lvbl_sr <= {r_lvbl_sr[BLANK_DLY-2:0], LVBL};
      r_red     <= w_show ? w_r : 5'd0;
      r_green   <= w_show ? w_g : 5'd0;
      r_blue    <= w_show ? w_b : 5'd0;
    end
  end

  assign red      = r_red;
  assign green    = r_green;
  assign blue     = r_blue;
  assign LHBL_dly = r_lhbl_sr[BLANK_DLY-1];
  assign LVBL_dly = r_lvbl_sr[BLANK_DLY-1];

endmodule

// File: tb/tb_jtlabrun_colmix.sv
// Directed bench for jtlabrun_colmix: table of palette entries with
// hand-decoded colours plus sequences for blanking, gating, collision, reset.
module tb_jtlabrun_colmix;

  typedef struct {
    logic [6:0] idx;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pxl_cen = 1'b0;
  logic [6:0] pxl = '0;
  logic       LHBL = 1'b0;
  logic       LVBL = 1'b0;
  logic [4:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  jtlabrun_colmix_if bus ();

  jtlabrun_colmix #(.BLANK_DLY(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .bus      (bus.slave),
    .pxl      (pxl),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  always #10 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  logic [7:0]  shadow [0:255];
  logic [14:0] prev_rgb = '0;
  logic        prev_lh  = 1'b0;
  logic        prev_lv  = 1'b0;
  vec_t        vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] decode(input logic [7:0] hi, input logic [7:0] lo);
    return {lo[4:0], hi[1:0], lo[7:5], hi[6:2]};  // {R, G, B}
  endfunction

  task automatic bus_idle();
    bus.cpu_cen = 1'b0;
    bus.pal_cs  = 1'b0;
    bus.cpu_rnw = 1'b1;
  endtask

  // Write one byte, checking old data in the write clk and new data after.
  task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] old;
    old = shadow[addr];
    bus.cpu_addr = addr;
    bus.cpu_dout = data;
    bus.cpu_rnw  = 1'b0;
    bus.pal_cs   = 1'b1;
    bus.cpu_cen  = 1'b1;
    tick();
    check("rd_during_wr_old", bus.pal_dout, old);
    shadow[addr] = data;
    bus_idle();
    tick();
    check("rd_after_wr_new", bus.pal_dout, data);
  endtask

  task automatic cpu_read(input logic [7:0] addr, input logic [7:0] exp, input string name);
    bus.cpu_addr = addr;
    bus.cpu_rnw  = 1'b1;
    bus.pal_cs   = 1'b1;
    tick();
    check(name, bus.pal_dout, exp);
    bus_idle();
  endtask

  // One pixel: pxl_cen for one clk (optionally with a CPU write in the same
  // clk), outputs compared against the pixel applied one pxl_cen earlier.
  task automatic pix(input logic [6:0] p, input logic lh, input logic lv,
                     input bit wr, input logic [7:0] waddr, input logic [7:0] wdata);
    logic [14:0] exp;
    exp = (prev_lh && prev_lv) ? prev_rgb : 15'd0;
    pxl     = p;
    LHBL    = lh;
    LVBL    = lv;
    pxl_cen = 1'b1;
    if (wr) begin
      bus.cpu_addr = waddr;
      bus.cpu_dout = wdata;
      bus.cpu_rnw  = 1'b0;
      bus.pal_cs   = 1'b1;
      bus.cpu_cen  = 1'b1;
    end
    tick();
    check("rgb", {red, green, blue}, exp);
    check("lhbl_dly", LHBL_dly, prev_lh);
    check("lvbl_dly", LVBL_dly, prev_lv);
    prev_rgb = decode(shadow[{p, 1'b0}], shadow[{p, 1'b1}]);
    prev_lh  = lh;
    prev_lv  = lv;
    if (wr) shadow[waddr] = wdata;
    pxl_cen = 1'b0;
    bus_idle();
    repeat (3) tick();
  endtask

  initial begin
    int zeros;
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;

    vecs[0] = '{idx: 7'd8,   hi: 8'h7C, lo: 8'h1F, r: 5'h1F, g: 5'h00, b: 5'h1F};
    vecs[1] = '{idx: 7'd9,   hi: 8'h03, lo: 8'hE0, r: 5'h00, g: 5'h1F, b: 5'h00};
    vecs[2] = '{idx: 7'd10,  hi: 8'h80, lo: 8'h00, r: 5'h00, g: 5'h00, b: 5'h00};
    vecs[3] = '{idx: 7'd11,  hi: 8'h7F, lo: 8'hFF, r: 5'h1F, g: 5'h1F, b: 5'h1F};
    vecs[4] = '{idx: 7'd12,  hi: 8'h15, lo: 8'h4A, r: 5'h0A, g: 5'h0A, b: 5'h05};
    vecs[5] = '{idx: 7'd127, hi: 8'h2A, lo: 8'hB5, r: 5'h15, g: 5'h15, b: 5'h0A};
    vecs[6] = '{idx: 7'd0,   hi: 8'hFF, lo: 8'hFF, r: 5'h1F, g: 5'h1F, b: 5'h1F};

    bus.cpu_addr = '0;
    bus.cpu_dout = '0;
    bus_idle();

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    check("rst_red", red, 5'd0);
    check("rst_green", green, 5'd0);
    check("rst_blue", blue, 5'd0);
    check("rst_pal_dout", bus.pal_dout, 8'h00);
    check("rst_lhbl_dly", LHBL_dly, 1'b0);
    check("rst_lvbl_dly", LVBL_dly, 1'b0);
    rst = 1'b0;

    // Clear entries used below so the model starts from known contents
    cpu_write(8'h0A, 8'h00);
    cpu_write(8'h0B, 8'h00);
    cpu_write(8'h30, 8'h00);

    // Table: write entry, read back, decode through the pipeline
    foreach (vecs[i]) begin
      cpu_write({vecs[i].idx, 1'b0}, vecs[i].hi);
      cpu_write({vecs[i].idx, 1'b1}, vecs[i].lo);
      cpu_read({vecs[i].idx, 1'b0}, vecs[i].hi, "tbl_rd_hi");
      cpu_read({vecs[i].idx, 1'b1}, vecs[i].lo, "tbl_rd_lo");
      pix(vecs[i].idx, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
      pix(vecs[i].idx, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
      check("tbl_red", red, vecs[i].r);
      check("tbl_green", green, vecs[i].g);
      check("tbl_blue", blue, vecs[i].b);
    end

    // Mirror 0x1710 -> low byte 0x10
    cpu_read(8'h10, 8'h7C, "mirror_rd");

    // Pipeline latency with changing pixels
    pix(7'd9,  1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    pix(7'd12, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check("lat_green_9", green, 5'h1F);
    pix(7'd8,  1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check("lat_red_12", red, 5'h0A);
    pix(7'd11, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);

    // Blanking: LHBL low for 4 pixels, LVBL low for 1
    zeros = 0;
    for (int j = 0; j < 12; j++) begin
      pix(7'd11, !(j >= 3 && j <= 6), (j != 8), 1'b0, 8'h00, 8'h00);
      if (j >= 1 && j <= 10 && {red, green, blue} == 15'd0) zeros++;
    end
    check("blank_zero_pixels", zeros, 5);

    // cpu_cen gating: one pulse among 8 clk of changing data
    bus.cpu_addr = 8'h30;
    bus.pal_cs   = 1'b1;
    bus.cpu_rnw  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.cpu_dout = 8'hA0 + 8'(k);
      bus.cpu_cen  = (k == 5);
      tick();
    end
    bus_idle();
    shadow[8'h30] = 8'hA5;
    cpu_read(8'h30, 8'hA5, "cen_gate");

    // Collision: write entry 5 high byte in the same clk video reads it
    cpu_write(8'h0A, 8'h7C);
    cpu_write(8'h0B, 8'h1F);
    pix(7'd5, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    pix(7'd5, 1'b1, 1'b1, 1'b1, 8'h0A, 8'h03);
    pix(7'd5, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check("coll_old_rgb", {red, green, blue}, {5'h1F, 5'h00, 5'h1F});
    pix(7'd5, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check("coll_new_rgb", {red, green, blue}, {5'h1F, 5'h18, 5'h00});

    // Reset mid-frame with non-zero outputs and read data
    cpu_read(8'h10, 8'h7C, "pre_rst_rd");
    bus.pal_cs = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pxl_cen = (k == 1);
      tick();
      check("midrst_rgb", {red, green, blue}, 15'd0);
      check("midrst_pal_dout", bus.pal_dout, 8'h00);
      check("midrst_blank", {LHBL_dly, LVBL_dly}, 2'b00);
    end
    pxl_cen = 1'b0;
    rst = 1'b0;
    bus_idle();
    prev_lh = 1'b0;
    prev_lv = 1'b0;
    pix(7'd8, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    pix(7'd8, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check("post_rst_rgb", {red, green, blue}, {5'h1F, 5'h00, 5'h1F});
    cpu_read(8'h10, 8'h7C, "post_rst_hi");
    cpu_read(8'h11, 8'h1F, "post_rst_lo");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
